// File: rtl/l0_pool_ctrl_pkg.sv
// Shared constants, types and helpers for the layer-0 feature-map pooling sequencer.
// Imported by the interface, the read-address generator and the top-level controller.
package l0_pkg;

    localparam int ROW   = 26;
    localparam int DW    = 18;
    localparam int AW    = 10;
    localparam int NPOOL = ROW / 2;
    localparam int FRAME = ROW * ROW;
    localparam int CW    = $clog2(NPOOL);

    typedef enum logic [1:0] {
        FILL,
        RD,
        WAIT,
        OUT
    } state_t;

    typedef logic signed [DW-1:0] sdata_t;

    // Strict greater-than keeps the earlier value on a tie.
    function automatic sdata_t smax(sdata_t a, sdata_t b);
        return (b > a) ? b : a;
    endfunction

    // Address of element ph (0..3, row-major) of 2x2 window (pr, pc).
    function automatic logic [AW-1:0] win_addr(
        logic [CW-1:0] pr,
        logic [CW-1:0] pc,
        logic [1:0]    ph
    );
        logic [AW-1:0] a;
        a = AW'(pr) * AW'(2 * ROW) + (AW'(pc) << 1);
        if (ph[1]) a = a + AW'(ROW);
        if (ph[0]) a = a + AW'(1);
        return a;
    endfunction

endpackage

// File: rtl/l0_pool_ctrl_if.sv
// Bundle of the conv0 input stream, the RAM write/read ports and the layer-1 output stream.
// slave: the pooling controller; master: whoever drives conv0 data, the RAM and layer 1.
interface l0_pool_ctrl_if;
    import l0_pkg::*;

    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          ram_wr;
    logic [AW-1:0] ram_addr_wr;
    logic [DW-1:0] ram_din;
    logic [AW-1:0] ram_addr_rd;
    logic [DW-1:0] ram_dout;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          out_last;
    logic          done;

    modport slave (
        input  in_valid, in_data, ram_dout, out_ready,
        output in_ready, ram_wr, ram_addr_wr, ram_din,
        output ram_addr_rd, out_valid, out_data, out_last, done
    );

    modport master (
        output in_valid, in_data, ram_dout, out_ready,
        input  in_ready, ram_wr, ram_addr_wr, ram_din,
        input  ram_addr_rd, out_valid, out_data, out_last, done
    );

endinterface

// File: rtl/l0_pool_ctrl_addr_gen.sv
// Pool window walker: pr/pc window counters, 4-phase read counter and registered read address.
// Ports: clear/step_ph/step_win control inputs; addr (registered), first_ph, last_ph, last_win flags.
module l0_pool_addr_gen
    import l0_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step_ph,
    input  logic          step_win,
    output logic [AW-1:0] addr,
    output logic          first_ph,
    output logic          last_ph,
    output logic          last_win
);

    logic [CW-1:0] pr_q, pr_d;
    logic [CW-1:0] pc_q, pc_d;
    logic [1:0]    ph_q, ph_d;
    logic [AW-1:0] addr_q, addr_d;

    // The address register is loaded from the next counter values, so
    // addr always matches the current (pr, pc, ph) with no extra delay.
    always_comb begin
        pr_d = pr_q;
        pc_d = pc_q;
        ph_d = ph_q;
        if (clear) begin
            pr_d = '0;
            pc_d = '0;
            ph_d = '0;
        end else if (step_win) begin
            ph_d = '0;
            if (pc_q == CW'(NPOOL - 1)) begin
                pc_d = '0;
                pr_d = pr_q + 1'b1;
            end else begin
                pc_d = pc_q + 1'b1;
            end
        end else if (step_ph) begin
            ph_d = ph_q + 1'b1;
        end
        addr_d = win_addr(pr_d, pc_d, ph_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pr_q   <= '0;
            pc_q   <= '0;
            ph_q   <= '0;
            addr_q <= '0;
        end else begin
            pr_q   <= pr_d;
            pc_q   <= pc_d;
            ph_q   <= ph_d;
            addr_q <= addr_d;
        end
    end

    assign addr     = addr_q;
    assign first_ph = (ph_q == 2'd0);
    assign last_ph  = (ph_q == 2'd3);
    assign last_win = (pr_q == CW'(NPOOL - 1)) && (pc_q == CW'(NPOOL - 1));

endmodule

// File: rtl/l0_pool_ctrl.sv
// Layer-0 RAM sequencer: FILL writes 26x26 conv0 samples, then 2x2 signed max-pool to layer 1.
// Ports: clk, rst (sync, active high), bus (slave view of l0_pool_ctrl_if).
module l0_pool_ctrl
    import l0_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    l0_pool_ctrl_if.slave  bus
);

    state_t        state_q, state_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    sdata_t        max_q, max_d;
    logic          load_q, load_d;
    logic          out_valid_q, out_valid_d;
    sdata_t        out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic          done_q, done_d;

    logic          in_ready;
    logic          wr;
    logic          ag_clear;
    logic          ag_step_ph;
    logic          ag_step_win;
    logic [AW-1:0] rd_addr;
    logic          first_ph;
    logic          last_ph;
    logic          last_win;
    sdata_t        dout;
    sdata_t        acc;

    l0_pool_addr_gen u_addr (
        .clk      (clk),
        .rst      (rst),
        .clear    (ag_clear),
        .step_ph  (ag_step_ph),
        .step_win (ag_step_win),
        .addr     (rd_addr),
        .first_ph (first_ph),
        .last_ph  (last_ph),
        .last_win (last_win)
    );

    assign dout = bus.ram_dout;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        max_d       = max_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        in_ready    = 1'b0;
        wr          = 1'b0;
        ag_clear    = 1'b0;
        ag_step_ph  = 1'b0;
        ag_step_win = 1'b0;
        // RAM data lags the address by one cycle: load_q marks the cycle
        // in which phase-0 data of the window is on ram_dout.
        load_d      = (state_q == RD) && first_ph;
        acc         = load_q ? dout : smax(max_q, dout);

        unique case (state_q)
            FILL: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    wr = 1'b1;
                    if (wcnt_q == AW'(FRAME - 1)) begin
                        wcnt_d   = '0;
                        ag_clear = 1'b1;
                        state_d  = RD;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            RD: begin
                if (!first_ph) max_d = acc;
                if (last_ph) state_d = WAIT;
                else         ag_step_ph = 1'b1;
            end
            WAIT: begin
                out_valid_d = 1'b1;
                out_data_d  = acc;
                out_last_d  = last_win;
                state_d     = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (last_win) begin
                        ag_clear = 1'b1;
                        done_d   = 1'b1;
                        state_d  = FILL;
                    end else begin
                        ag_step_win = 1'b1;
                        state_d     = RD;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            wcnt_q      <= '0;
            max_q       <= '0;
            load_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            max_q       <= max_d;
            load_q      <= load_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.ram_wr      = wr;
    assign bus.ram_addr_wr = wcnt_q;
    assign bus.ram_din     = wr ? bus.in_data : '0;
    assign bus.ram_addr_rd = rd_addr;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_last    = out_last_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_l0_pool_ctrl.sv
// Directed bench for l0_pool_ctrl with a behavioural 1-cycle-latency RAM.
// Frames: gappy ramp with backpressure, back-to-back ramp+1000, reset mid-pool, negative data.
module tb_l0_pool_ctrl;
    import l0_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    int   done_cnt;
    int   t_fill;

    logic [DW-1:0] mem [0:1023];

    l0_pool_ctrl_if bus ();

    l0_pool_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.ram_wr) mem[bus.ram_addr_wr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr_rd];
    end

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int data_of(input int mode, input int base, input int i);
        if (mode == 0) return base + i;
        case (i)
            2:  return -5;
            3:  return -3;
            28: return -9;
            29: return -7;
            4:  return 7;
            5:  return -2;
            30: return 3;
            31: return -8;
            default: return -1000;
        endcase
    endfunction

    // Window (r,c) of a ramp peaks at its bottom-right element.
    function automatic int exp_res(input int mode, input int base, input int idx);
        int r;
        int c;
        r = idx / NPOOL;
        c = idx % NPOOL;
        if (mode == 0) return base + (2 * r + 1) * ROW + 2 * c + 1;
        if (idx == 1) return -3;
        if (idx == 2) return 7;
        return -1000;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_ram_wr"}, bus.ram_wr, 0);
        chk({tag, "_ram_addr_wr"}, bus.ram_addr_wr, 0);
        chk({tag, "_ram_din"}, bus.ram_din, 0);
        chk({tag, "_ram_addr_rd"}, bus.ram_addr_rd, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_data"}, bus.out_data, 0);
        chk({tag, "_out_last"}, bus.out_last, 0);
        chk({tag, "_done"}, bus.done, 0);
    endtask

    task automatic fill(input int mode, input int base, input bit gaps,
                        output int t_end);
        int i;
        int n;
        i = 0;
        n = 0;
        t_end = 0;
        while (i < FRAME && n < 8 * FRAME) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.in_data   = DW'(data_of(mode, base, i));
            #1;
            chk("fill_in_ready", bus.in_ready, 1);
            chk("fill_ram_wr", bus.ram_wr, bus.in_valid);
            chk("fill_done", bus.done, 0);
            if (bus.in_valid) begin
                chk("fill_addr", bus.ram_addr_wr, i);
                chk("fill_din", $signed(bus.ram_din), data_of(mode, base, i));
                t_end = cyc;
                i++;
            end
            n++;
        end
        if (i < FRAME) chk("fill_timeout", i, FRAME);
    endtask

    task automatic pool(input int mode, input int base, input int stop_after,
                        input int bp, input int t_f, input bit drive_in);
        int idx;
        int hold;
        int last_hs;
        bit seen;
        bit fin;
        logic [AW-1:0] hold_addr;
        idx = 0;
        hold = 0;
        last_hs = 0;
        seen = 1'b0;
        fin = 1'b0;
        hold_addr = '0;
        for (int n = 0; n < 3000 && !fin; n++) begin
            @(negedge clk);
            bus.in_valid  = drive_in;
            bus.in_data   = DW'(-1);
            bus.out_ready = (idx == 0 && hold < bp) ? 1'b0 : 1'b1;
            #1;
            if (drive_in) begin
                chk("pool_in_ready", bus.in_ready, 0);
                chk("pool_ram_wr", bus.ram_wr, 0);
            end
            if (bus.out_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                chk("latency", cyc - t_f, 6);
            end
            if (seen && bus.out_ready === 1'b0) begin
                chk("bp_valid", bus.out_valid, 1);
                chk("bp_data", $signed(bus.out_data), exp_res(mode, base, 0));
                chk("bp_last", bus.out_last, 0);
                if (hold == 0) hold_addr = bus.ram_addr_rd;
                else chk("bp_rd_addr", bus.ram_addr_rd, hold_addr);
                hold++;
            end else if (bus.out_valid === 1'b1) begin
                chk("res_data", $signed(bus.out_data), exp_res(mode, base, idx));
                chk("res_last", bus.out_last, (idx == NPOOL * NPOOL - 1) ? 1 : 0);
                if (idx >= 1 && idx <= 3) chk("res_gap", cyc - last_hs, 6);
                last_hs = cyc;
                idx++;
                if (idx == stop_after) fin = 1'b1;
            end
        end
        if (!fin) chk("pool_timeout", idx, stop_after);
        if (fin && idx == NPOOL * NPOOL) begin
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            #1;
            chk("done_pulse", bus.done, 1);
            chk("done_in_ready", bus.in_ready, 1);
            chk("done_out_valid", bus.out_valid, 0);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        done_cnt      = 0;
        t_fill        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check_reset("por");
        rst = 1'b0;

        fill(0, 0, 1'b1, t_fill);
        pool(0, 0, NPOOL * NPOOL, 10, t_fill, 1'b1);
        chk("done_cnt_1", done_cnt, 1);

        fill(0, 1000, 1'b0, t_fill);
        pool(0, 1000, NPOOL * NPOOL, 0, t_fill, 1'b0);
        chk("done_cnt_2", done_cnt, 2);

        fill(0, 0, 1'b0, t_fill);
        pool(0, 0, 50, 0, t_fill, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        check_reset("mid");
        rst = 1'b0;
        chk("done_cnt_rst", done_cnt, 2);

        fill(0, 0, 1'b0, t_fill);
        pool(0, 0, NPOOL * NPOOL, 0, t_fill, 1'b0);

        fill(1, 0, 1'b0, t_fill);
        pool(1, 0, NPOOL * NPOOL, 0, t_fill, 1'b0);
        chk("done_cnt_end", done_cnt, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/l0_pool_ctrl.md
Name: l0_pool_ctrl

Overview:
- Sequencer for the layer-0 feature-map RAM: 26x26 entries, 18-bit signed, 1-cycle registered read.
- FILL phase: takes the convolution output stream and writes it to the RAM in raster order.
- POOL phase: reads every non-overlapping 2x2 window and streams 13x13 = 169 signed-max results to layer 1 with a valid/ready handshake.
- Sits between the conv0 engine and the layer-1 input, and owns both RAM ports exclusively.

Parameters:
- ROW, 26, feature-map side length (entries per row).
- DW, 18, data width (two's-complement fixed point).
- AW, 10, RAM address width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  conv0 sample available.
- in_data  in  DW  conv0 sample.
- in_ready  out  1  block accepts a sample this cycle.
- ram_wr  out  1  RAM write enable.
- ram_addr_wr  out  AW  RAM write address.
- ram_din  out  DW  RAM write data.
- ram_addr_rd  out  AW  RAM read address.
- ram_dout  in  DW  RAM read data, valid the cycle after ram_addr_rd.
- out_valid  out  1  pooled result available.
- out_data  out  DW  pooled result (signed max of 4).
- out_ready  in  1  layer 1 accepts the result.
- out_last  out  1  qualifies the 169th result of a frame.
- done  out  1  one-cycle pulse after the last result handshake.

Behaviour:
- Reset values (cycle after rst sampled high):
  - State FILL; write count, pool row/col and read phase all 0.
  - in_ready=1; ram_wr=0; ram_addr_wr=0; ram_din=0; ram_addr_rd=0.
  - out_valid=0; out_data=0; out_last=0; done=0.
- rst takes priority over all other inputs, including mid-FILL and mid-POOL; any partial frame is discarded.
- States: FILL -> RD (4 read cycles) -> WAIT (data return) -> OUT (hold) -> RD or FILL.
- FILL:
  - in_ready=1 combinationally.
  - On in_valid&&in_ready: ram_wr=1, ram_din=in_data, ram_addr_wr=write count, then the count increments. ram_wr, ram_addr_wr and ram_din are combinational from the handshake; there is no added latency.
  - Gaps in in_valid are allowed.
  - After the write at address 675: the next state is RD, the write count clears, and pool row = pool col = 0.
- RD:
  - in_ready=0; in_valid is ignored and no write occurs.
  - Window base = 2*ROW*pr + 2*pc.
  - Phases 0..3 drive ram_addr_rd = base, base+1, base+ROW, base+ROW+1 on four consecutive cycles.
  - The address is registered, so it is presented to the RAM in the phase cycle.
- WAIT / accumulate:
  - ram_dout for phase p is captured in cycle p+1.
  - Phase 0 data loads the running max; phases 1..3 update it with a signed compare.
  - The cycle after phase-3 data: out_valid=1, out_data=max, out_last=(pr==12 && pc==12).
- Window latency: first read address issued in cycle k; out_valid high in cycle k+5.
- OUT:
  - out_valid, out_data and out_last stay stable until out_valid&&out_ready.
  - On the handshake, out_valid drops next cycle and pc increments.
  - pc wraps 12 -> 0 with pr incrementing.
  - Reads for the next window begin the cycle after the handshake.
- Last window: the handshake on out_last sets done=1 for exactly one cycle and returns the block to FILL with in_ready=1 that cycle. Back-to-back frames are supported.
- Arithmetic:
  - Addresses are computed in AW bits; the maximum address is 675, so no overflow is possible.
  - The compare is signed DW-bit; on a tie the earlier value is kept (the result is identical either way).
- out_ready held high gives a throughput of 1 result per 6 cycles.
- out_ready is don't-care while out_valid=0.

Decomposition:
- Package l0_pkg:
  - ROW, DW, AW, and NPOOL=ROW/2 constants.
  - Frame size constant ROW*ROW = 676.
  - State enum typedef {FILL, RD, WAIT, OUT}.
  - Signed data typedef logic signed [DW-1:0].
- One sub-module, l0_pool_addr_gen:
  - Holds the pr/pc counters and the phase counter.
  - Produces ram_addr_rd plus first/last-phase and last-window flags.
  - Advances on a step input.
- The FSM and max accumulator stay in l0_pool_ctrl.

Test Plan:
- Ramp fill: in_data=i for i=0..675, out_ready=1 -> 169 results; first=27, second=29, 14th=79, last=675 with out_last=1, then done pulses once.
- Negative data: window values -5, -3, -9, -7 (all others -1000) -> corresponding result = -3. Checks the signed compare, not unsigned.
- Backpressure: out_ready=0 for 10 cycles while the first result is pending -> out_valid/out_data (27) held constant, no new ram_addr_rd activity, pc unchanged.
- Input gaps: in_valid toggled pseudo-randomly during FILL -> exactly 676 writes at addresses 0..675 in order; in_ready=0 and ram_wr=0 throughout POOL even with in_valid=1.
- Reset mid-POOL: assert rst after the 50th result -> next cycle in FILL with all outputs at reset values. A fresh ramp frame then yields first result 27.
- Back-to-back frames: second frame is a ramp+1000 started the cycle after done -> first result 1027, last 1675, done pulses twice in total.
